// File: rtl/wave_pkg.sv
// wave_pkg: shared constants, FSM encoding and trigger rule for wave_trig_capture
package wave_pkg;
  localparam int LEN_DEFAULT = 800;
  localparam int SAMPLE_W = 8;
  localparam int AUTO_TIMEOUT_DEFAULT = 4096;
  typedef logic [SAMPLE_W-1:0] sample_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;
  function automatic logic edge_hit(input logic fall, input sample_t prev, input sample_t cur,
                                    input sample_t lvl);
    return fall ? (prev > lvl && cur <= lvl) : (prev < lvl && cur >= lvl);
  endfunction
endpackage

// File: rtl/wave_decimator.sv
// wave_decimator: passes one of every decim adc_valid beats; restart returns the phase to 0
module wave_decimator (
  input  logic        adc_clk,
  input  logic        adc_rst,
  input  logic        adc_valid,
  input  logic [15:0] decim,
  input  logic        restart,
  output logic        strobe
);
  logic [15:0] cnt_q, cnt_d;
  logic wrap;
  assign wrap = decim <= 16'd1 || cnt_q >= decim - 16'd1;
  assign strobe = adc_valid && cnt_q == '0;
  assign cnt_d = restart ? '0 : !adc_valid ? cnt_q : wrap ? '0 : cnt_q + 16'd1;
  always_ff @(posedge adc_clk) cnt_q <= adc_rst ? '0 : cnt_d;
endmodule

// File: rtl/wave_trig_capture.sv
// wave_trig_capture: edge-triggered line capture of a decimated ADC stream;
// defining WAVE_TRIG_AUTO_EN adds the timeout-forced trigger (auto_mode, trig_auto).
module wave_trig_capture
  import wave_pkg::*;
#(
  parameter int LEN = LEN_DEFAULT,
  parameter int AUTO_TIMEOUT = AUTO_TIMEOUT_DEFAULT
) (
  input  logic                adc_clk,
  input  logic                adc_rst,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                enable,
  input  logic                single,
  input  logic                trig_edge,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [15:0]         decim,
  input  logic [15:0]         holdoff,
  input  logic                auto_mode,
  output logic                wr_valid,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                wr_line_start,
  output logic                trig_auto,
  output logic                busy
);
  logic [1:0] state_q, state_d;
  logic [9:0] smp_q, smp_d;
  logic [15:0] hold_q, hold_d, decim_q, holdoff_q;
  logic [SAMPLE_W-1:0] level_q, prev_q, s1_data_q, wr_data_q;
  logic edge_q, single_q, prev_ok_q, s1_valid_q, wr_valid_q, line_start_q;
  logic strobe, in_wait, hit, forced, fire, emit, enter_wait, hold_done;

  wave_decimator u_decim (
    .adc_clk   (adc_clk),
    .adc_rst   (adc_rst),
    .adc_valid (adc_valid),
    .decim     (decim_q),
    .restart   (enter_wait),
    .strobe    (strobe)
  );

  assign in_wait = state_q == ST_WAIT;
  assign hit = strobe && prev_ok_q && edge_hit(edge_q, prev_q, adc_data, level_q);
  assign fire = in_wait && enable && (hit || forced);
  assign emit = strobe && (state_q == ST_CAPT || fire);
  assign hold_done = holdoff_q <= 16'd1 || hold_q >= holdoff_q - 16'd1;
  assign enter_wait = !in_wait && state_d == ST_WAIT;

  // The trigger sample is line sample 0, so the count leaves WAIT already at 1.
  always_comb begin
    state_d = state_q;
    smp_d = smp_q;
    hold_d = '0;
    case (state_q)
      ST_IDLE: state_d = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable) state_d = ST_IDLE;
        else if (fire) begin
          state_d = LEN > 1 ? ST_CAPT : ST_HOLD;
          smp_d = 10'(LEN > 1);
        end
      end
      ST_CAPT: if (strobe) begin
        state_d = smp_q == 10'(LEN - 1) ? ST_HOLD : ST_CAPT;
        smp_d = smp_q == 10'(LEN - 1) ? '0 : smp_q + 10'd1;
      end
      default: begin
        state_d = !hold_done ? ST_HOLD : enable && !single_q ? ST_WAIT : ST_IDLE;
        hold_d = hold_done ? '0 : hold_q + 16'd1;
      end
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state_q <= ST_IDLE;
      smp_q <= '0;
      hold_q <= '0;
      decim_q <= '0;
      holdoff_q <= '0;
      level_q <= '0;
      edge_q <= 1'b0;
      single_q <= 1'b0;
      prev_q <= '0;
      prev_ok_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q <= '0;
      line_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q <= smp_d;
      hold_q <= hold_d;
      if (enter_wait) begin
        decim_q <= decim;
        holdoff_q <= holdoff;
        level_q <= trig_level;
        edge_q <= trig_edge;
        single_q <= single;
      end
      if (enter_wait) prev_ok_q <= 1'b0;
      else if (in_wait && strobe) begin
        prev_ok_q <= 1'b1;
        prev_q <= adc_data;
      end
      s1_valid_q <= emit;
      if (emit) s1_data_q <= adc_data;
      wr_valid_q <= s1_valid_q;
      wr_data_q <= s1_data_q;
      line_start_q <= fire;
    end
  end

`ifdef WAVE_TRIG_AUTO_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] to_q;
  logic auto_q, trig_auto_q;
  assign forced = strobe && auto_q && to_q == TW'(AUTO_TIMEOUT);
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      to_q <= '0;
      auto_q <= 1'b0;
      trig_auto_q <= 1'b0;
    end else begin
      if (enter_wait) begin
        to_q <= '0;
        auto_q <= auto_mode;
      end else if (in_wait && strobe && to_q != TW'(AUTO_TIMEOUT)) to_q <= to_q + TW'(1);
      if (fire) trig_auto_q <= !hit;
    end
  end
  assign trig_auto = trig_auto_q;
`else
  logic unused_auto;
  assign unused_auto = auto_mode | (AUTO_TIMEOUT < 0);
  assign forced = 1'b0;
  assign trig_auto = 1'b0;
`endif

  assign wr_valid = wr_valid_q;
  assign wr_data = wr_data_q;
  assign wr_line_start = line_start_q;
  assign busy = state_q != ST_IDLE;
endmodule
